instr_fetch_unit: RTL

- Instruction fetch stage directly upstream of the controller.
- Holds the PC, issues requests to instruction memory and keeps the current instruction register (IR) that drives the controller's 16-bit ins input.
- Applies the controller's pc1sel/pc2sel/zero decisions to select the next PC.
- Carries a one-entry sequential prefetch buffer; taken control transfers squash it.

---
 rtl/instr_fetch_unit.sv | 165 ++++++++++++++++
 1 files changed

// File: rtl/instr_fetch_unit.sv
// instr_fetch_unit: PC, one-outstanding imem requests, IR and a
// one-entry sequential prefetch buffer; applies jump/branchz redirects.
// Ports:
//   clk, rst_n                 clock, async active-low reset
//   imem_req/addr/ack/rdata    instruction memory request/transfer
//   ins, ins_pc, ins_valid     IR contents presented to the controller
//   ins_ready                  controller retires ins this cycle
//   pc1sel, pc2sel, zero       branchz / jump decision for the IR entry
module instr_fetch_unit #(
    parameter int              PC_W     = 12,
    parameter logic [PC_W-1:0] RESET_PC = '0,
    parameter int              BR_OFF_W = 8
) (
    input  logic            clk,
    input  logic            rst_n,
    output logic            imem_req,
    output logic [PC_W-1:0] imem_addr,
    input  logic            imem_ack,
    input  logic [15:0]     imem_rdata,
    output logic [15:0]     ins,
    output logic [PC_W-1:0] ins_pc,
    output logic            ins_valid,
    input  logic            ins_ready,
    input  logic            pc1sel,
    input  logic            pc2sel,
    input  logic            zero
);

    logic [PC_W-1:0] fetch_pc;
    logic [15:0]     pf_data;
    logic [PC_W-1:0] pf_pc;
    logic            pf_valid;
    logic            drop;

    logic [15:0]     ir_n;
    logic [PC_W-1:0] irpc_n;
    logic            irv_n;
    logic [15:0]     pf_n;
    logic [PC_W-1:0] pfpc_n;
    logic            pfv_n;
    logic [PC_W-1:0] fpc_n;
    logic            drop_n;
    logic            req_n;
    logic [PC_W-1:0] addr_n;

    logic            xfer;
    logic            retire;
    logic            redirect;
    logic            keep;
    logic [PC_W-1:0] seq_pc;
    logic [PC_W-1:0] jmp_tgt;
    logic [PC_W-1:0] br_tgt;
    logic [PC_W-1:0] tgt;
    logic [BR_OFF_W-1:0] br_off;

    assign xfer   = imem_req && imem_ack;
    assign retire = ins_valid && ins_ready;
    assign seq_pc = ins_pc + PC_W'(1);
    assign br_off = ins[BR_OFF_W-1:0];
    assign br_tgt = seq_pc
                  + {{(PC_W-BR_OFF_W){br_off[BR_OFF_W-1]}}, br_off};

    generate
        if (PC_W > 12) begin : g_wide
            assign jmp_tgt = {ins_pc[PC_W-1:12], ins[11:0]};
        end else begin : g_narrow
            assign jmp_tgt = ins[PC_W-1:0];
        end
    endgenerate

    always_comb begin
        tgt = seq_pc;
        if (pc2sel)
            tgt = jmp_tgt;
        else if (pc1sel && zero)
            tgt = br_tgt;
    end

    // A "taken" transfer that lands on ins_pc+1 is just sequential flow.
    assign redirect = retire && (tgt != seq_pc);
    assign keep     = xfer && !drop && !redirect;

    always_comb begin
        ir_n   = ins;
        irpc_n = ins_pc;
        irv_n  = ins_valid;
        pf_n   = pf_data;
        pfpc_n = pf_pc;
        pfv_n  = pf_valid;
        fpc_n  = fetch_pc;
        drop_n = drop;
        req_n  = imem_req;
        addr_n = imem_addr;
        if (keep) begin
            pf_n   = imem_rdata;
            pfpc_n = imem_addr;
        end
        if (redirect) begin
            irv_n  = 1'b0;
            pfv_n  = 1'b0;
            fpc_n  = tgt;
            // In-flight fetch belongs to the old path; discard it at ack.
            drop_n = imem_req && !imem_ack;
        end else begin
            if (xfer)
                drop_n = 1'b0;
            if (keep)
                fpc_n = fetch_pc + PC_W'(1);
            if (retire) begin
                if (pf_valid) begin
                    ir_n   = pf_data;
                    irpc_n = pf_pc;
                    pfv_n  = keep;
                end else if (keep) begin
                    ir_n   = imem_rdata;
                    irpc_n = imem_addr;
                end else begin
                    irv_n  = 1'b0;
                end
            end else if (keep) begin
                if (!ins_valid) begin
                    ir_n   = imem_rdata;
                    irpc_n = imem_addr;
                    irv_n  = 1'b1;
                end else begin
                    pfv_n  = 1'b1;
                end
            end
        end
        // A pending request is never retargeted.
        if (imem_req && !imem_ack) begin
            req_n = 1'b1;
        end else begin
            req_n  = drop_n || !irv_n || !pfv_n;
            addr_n = fpc_n;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            imem_req  <= 1'b0;
            imem_addr <= RESET_PC;
            ins       <= 16'h0000;
            ins_pc    <= '0;
            ins_valid <= 1'b0;
            pf_data   <= 16'h0000;
            pf_pc     <= '0;
            pf_valid  <= 1'b0;
            fetch_pc  <= RESET_PC;
            drop      <= 1'b0;
        end else begin
            imem_req  <= req_n;
            imem_addr <= addr_n;
            ins       <= ir_n;
            ins_pc    <= irpc_n;
            ins_valid <= irv_n;
            pf_data   <= pf_n;
            pf_pc     <= pfpc_n;
            pf_valid  <= pfv_n;
            fetch_pc  <= fpc_n;
            drop      <= drop_n;
        end
    end

endmodule
